// File: rtl/shared_imem_server.sv
`default_nettype none
// ============================================================================
// Module   : shared_imem_server
// Desc     : Responder side of the cluster instruction-fetch interface.
//            Arbitrates per-CPU fetch requests round-robin onto a single
//            synchronous-read ROM port and returns each word to its
//            requester with a fixed two-cycle grant-to-response latency.
// Revision : 1.0 - initial release
// ============================================================================
module shared_imem_server #(
    parameter int          nCPUs    = 3,
    parameter int          romDepth = 256,
    parameter logic [31:0] nopInstr = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [nCPUs-1:0]              reqValid,
    input  logic [nCPUs-1:0][31:0]        reqAddr,
    output logic [nCPUs-1:0]              reqReady,
    output logic [nCPUs-1:0]              rspValid,
    output logic [nCPUs-1:0][31:0]        rspData,
    output logic [nCPUs-1:0]              addrErr,
    output logic                          memRdEn,
    output logic [$clog2(romDepth)-1:0]   memAddr,
    input  logic [31:0]                   memData,
    output logic [31:0]                   conflictCount
);

    localparam int                 c_ADDR_W   = $clog2(romDepth);
    localparam int                 c_IDX_W    = (nCPUs > 1) ? $clog2(nCPUs) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(nCPUs - 1);

    // Arbitration state
    logic [nCPUs-1:0]       r_pending;
    logic [c_IDX_W-1:0]     r_ptr;

    // Stage 1: request accepted, ROM read in progress
    logic                   r_s1Valid;
    logic [c_IDX_W-1:0]     r_s1Idx;
    logic                   r_s1Err;
    logic                   r_s1Oor;

    // Stage 2: response registers
    logic [nCPUs-1:0]       r_rspValid;
    logic [nCPUs-1:0]       r_addrErr;
    logic [nCPUs-1:0][31:0] r_rspData;
    logic [31:0]            r_conflictCount;

    logic [nCPUs-1:0]       w_eligible;
    logic                   w_grantValid;
    logic [c_IDX_W-1:0]     w_grantIdx;
    logic                   w_multi;
    logic [31:0]            w_grantAddr;
    logic                   w_misaligned;
    logic                   w_outOfRange;
    logic [nCPUs-1:0]       w_s1Hit;

    // Round-robin search starting at the priority pointer; also flags contention.
    always_comb begin
        int   cand;
        logic seen;
        w_eligible   = rst_n ? (reqValid & ~r_pending) : '0;
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_multi      = 1'b0;
        seen         = 1'b0;
        cand         = 0;
        for (int k = 0; k < nCPUs; k++) begin
            cand = int'(r_ptr) + k;
            if (cand >= nCPUs) begin
                cand = cand - nCPUs;
            end
            if (!w_grantValid && w_eligible[cand]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = c_IDX_W'(cand);
            end
            if (w_eligible[k]) begin
                if (seen) begin
                    w_multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    // Drive the ROM port and one-hot grant from the winning request.
    always_comb begin
        w_grantAddr  = reqAddr[w_grantIdx];
        w_misaligned = |w_grantAddr[1:0];
        w_outOfRange = (w_grantAddr[31:2] >= 30'(romDepth));
        memRdEn      = w_grantValid;
        memAddr      = w_grantAddr[2 +: c_ADDR_W];
        reqReady     = '0;
        for (int k = 0; k < nCPUs; k++) begin
            reqReady[k] = w_grantValid && (w_grantIdx == c_IDX_W'(k));
        end
    end

    // Which CPU the stage-1 entry belongs to (one-hot, or zero when empty).
    always_comb begin
        w_s1Hit = '0;
        for (int k = 0; k < nCPUs; k++) begin
            w_s1Hit[k] = r_s1Valid && (r_s1Idx == c_IDX_W'(k));
        end
    end

    // Priority pointer advance and per-CPU outstanding-request flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_pending <= '0;
        end else begin
            if (w_grantValid) begin
                r_ptr <= (w_grantIdx == c_LAST_IDX) ? '0 : w_grantIdx + 1'b1;
            end
            for (int k = 0; k < nCPUs; k++) begin
                if (reqReady[k]) begin
                    r_pending[k] <= 1'b1;
                end else if (r_rspValid[k]) begin
                    r_pending[k] <= 1'b0;
                end
            end
        end
    end

    // Stage 1: remember who was granted and how the address was classified.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Idx   <= '0;
            r_s1Err   <= 1'b0;
            r_s1Oor   <= 1'b0;
        end else begin
            r_s1Valid <= w_grantValid;
            r_s1Idx   <= w_grantIdx;
            r_s1Err   <= w_misaligned | w_outOfRange;
            r_s1Oor   <= w_outOfRange;
        end
    end

    // Stage 2: capture ROM data (or NOP when out of range) and pulse the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rspValid <= '0;
            r_addrErr  <= '0;
            for (int k = 0; k < nCPUs; k++) begin
                r_rspData[k] <= nopInstr;
            end
        end else begin
            r_rspValid <= w_s1Hit;
            r_addrErr  <= w_s1Hit & {nCPUs{r_s1Err}};
            for (int k = 0; k < nCPUs; k++) begin
                if (w_s1Hit[k]) begin
                    r_rspData[k] <= r_s1Oor ? nopInstr : memData;
                end
            end
        end
    end

    // Count cycles where two or more CPUs competed for the ROM port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conflictCount <= '0;
        end else if (w_multi) begin
            r_conflictCount <= r_conflictCount + 32'd1;
        end
    end

    assign rspValid      = r_rspValid;
    assign addrErr       = r_addrErr;
    assign rspData       = r_rspData;
    assign conflictCount = r_conflictCount;

endmodule
`default_nettype wire

// File: tb/tb_shared_imem_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_imem_server
// Desc     : Self-checking bench for shared_imem_server. A transaction-level
//            model (round-robin grant, queue of due responses) is compared
//            against the DUT every cycle; directed tests add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_imem_server;

    localparam int          N     = 3;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        reqValid;
    logic [N-1:0][31:0]  reqAddr;
    logic [N-1:0]        reqReady;
    logic [N-1:0]        rspValid;
    logic [N-1:0][31:0]  rspData;
    logic [N-1:0]        addrErr;
    logic                memRdEn;
    logic [7:0]          memAddr;
    logic [31:0]         memData;
    logic [31:0]         conflictCount;

    shared_imem_server #(
        .nCPUs    (N),
        .romDepth (DEPTH),
        .nopInstr (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reqValid      (reqValid),
        .reqAddr       (reqAddr),
        .reqReady      (reqReady),
        .rspValid      (rspValid),
        .rspData       (rspData),
        .addrErr       (addrErr),
        .memRdEn       (memRdEn),
        .memAddr       (memAddr),
        .memData       (memData),
        .conflictCount (conflictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROM
    logic [31:0] rom [0:DEPTH-1];
    always @(posedge clk) begin
        if (memRdEn) memData <= rom[memAddr];
    end

    int n_tests;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]  cpu;
        logic [31:0] data;
        logic        err;
        logic [63:0] due;
    } rsp_t;

    rsp_t        m_q[$];
    int          m_ptr;
    bit          m_pend [N];
    bit          m_vld  [N];
    bit          m_err  [N];
    logic [31:0] m_data [N];
    logic [31:0] m_cnt;
    logic [63:0] m_cyc;
    bit          m_live;
    int          preset_seq;
    logic [31:0] preset_val;

    function automatic int exp_grant();
        int c;
        if (rst_n !== 1'b1) return -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (reqValid[c] && !m_pend[c]) return c;
        end
        return -1;
    endfunction

    function automatic int n_elig();
        int n;
        n = 0;
        if (rst_n !== 1'b1) return 0;
        for (int k = 0; k < N; k++) if (reqValid[k] && !m_pend[k]) n++;
        return n;
    endfunction

    initial begin : p_model
        int          g;
        int          seen_seq;
        logic [29:0] word;
        logic        oor;
        logic [31:0] d;
        logic        e;
        rsp_t        r;
        logic [N-1:0] ev;
        logic [N-1:0] ee;
        logic [31:0] er;
        seen_seq = 0;
        m_live   = 1'b0;
        m_cyc    = '0;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b0) begin
                m_live = 1'b1;
                m_ptr  = 0;
                m_cnt  = '0;
                m_q.delete();
                for (int k = 0; k < N; k++) begin
                    m_pend[k] = 1'b0; m_vld[k] = 1'b0; m_err[k] = 1'b0; m_data[k] = NOP;
                end
                m_cyc++;
            end else if (m_live) begin
                g = exp_grant();
                if (n_elig() >= 2) m_cnt++;
                for (int k = 0; k < N; k++) if (m_vld[k]) m_pend[k] = 1'b0;
                if (g >= 0) begin
                    word = reqAddr[g][31:2];
                    oor  = (word >= 30'(DEPTH));
                    d    = oor ? NOP : rom[word[7:0]];
                    e    = oor || (reqAddr[g][1:0] != 2'b00);
                    m_pend[g] = 1'b1;
                    m_ptr     = (g + 1) % N;
                    m_q.push_back('{cpu: 2'(g), data: d, err: e, due: m_cyc + 2});
                end
                m_cyc++;
                for (int k = 0; k < N; k++) begin m_vld[k] = 1'b0; m_err[k] = 1'b0; end
                while (m_q.size() > 0 && m_q[0].due == m_cyc) begin
                    r = m_q.pop_front();
                    m_vld[r.cpu]  = 1'b1;
                    m_err[r.cpu]  = r.err;
                    m_data[r.cpu] = r.data;
                end
            end
            @(negedge clk);
            #2;
            if (preset_seq != seen_seq) begin
                seen_seq = preset_seq;
                m_cnt    = preset_val;
            end
            if (m_live) begin
                g  = exp_grant();
                er = (g >= 0) ? (32'd1 << g) : 32'd0;
                chk("reqReady", 32'(reqReady), er);
                chk("memRdEn", 32'(memRdEn), 32'(g >= 0));
                if (g >= 0) chk("memAddr", 32'(memAddr), 32'(reqAddr[g][9:2]));
                for (int k = 0; k < N; k++) begin ev[k] = m_vld[k]; ee[k] = m_err[k]; end
                chk("rspValid", 32'(rspValid), 32'(ev));
                chk("addrErr", 32'(addrErr), 32'(ee));
                for (int k = 0; k < N; k++) chk("rspData", rspData[k], m_data[k]);
                chk("conflictCount", conflictCount, m_cnt);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        rst_n    = 1'b0;
        reqValid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int gc [N];

    initial begin : p_stim
        n_tests    = 0;
        n_fail     = 0;
        preset_seq = 0;
        preset_val = '0;
        memData    = '0;
        reqAddr    = '0;
        reqValid   = '0;
        rst_n      = 1'b0;
        for (int k = 0; k < DEPTH; k++) rom[k] = 32'h5A000003 + (32'(k) << 8);
        rom[0]  = 32'h00000493;
        rom[12] = 32'h00100513;

        // Test 1: single fetch, two-cycle latency
        do_reset();
        #3;
        chk("T1 reset rspData0", rspData[0], 32'h00000013);
        chk("T1 reset conflictCount", conflictCount, 32'd0);
        @(negedge clk);
        reqValid = 3'b001; reqAddr[0] = 32'h0;
        #3;
        chk("T1 grant", 32'(reqReady), 32'h1);
        chk("T1 memAddr", 32'(memAddr), 32'h0);
        @(negedge clk); reqValid = '0;
        @(negedge clk); #3;
        chk("T1 rspValid", 32'(rspValid), 32'h1);
        chk("T1 rspData0", rspData[0], 32'h00000493);
        chk("T1 addrErr", 32'(addrErr), 32'h0);

        // Test 2: three simultaneous requests after reset
        do_reset();
        reqValid = 3'b111;
        reqAddr[0] = 32'h0; reqAddr[1] = 32'h0; reqAddr[2] = 32'h30;
        #3; chk("T2 grant t", 32'(reqReady), 32'h1);
        @(negedge clk); #3; chk("T2 grant t+1", 32'(reqReady), 32'h2);
        @(negedge clk); #3; chk("T2 grant t+2", 32'(reqReady), 32'h4);
        chk("T2 rspValid t+2", 32'(rspValid), 32'h1);
        @(negedge clk); reqValid = '0;
        #3; chk("T2 rspValid t+3", 32'(rspValid), 32'h2);
        chk("T2 conflictCount", conflictCount, 32'd2);
        @(negedge clk); #3;
        chk("T2 rspValid t+4", 32'(rspValid), 32'h4);
        chk("T2 rspData2", rspData[2], 32'h00100513);

        // Test 3: all CPUs requesting continuously for 30 cycles
        for (int k = 0; k < N; k++) gc[k] = 0;
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            reqValid = 3'b111;
            for (int k = 0; k < N; k++) reqAddr[k] = 32'((c * 3 + k) * 4 + ((c + k) % 4));
            #3;
            for (int k = 0; k < N; k++) if (reqReady[k]) gc[k]++;
            @(negedge clk);
        end
        reqValid = '0;
        for (int k = 0; k < N; k++) chk("T3 grants per cpu", 32'(gc[k]), 32'd10);
        repeat (4) @(negedge clk);

        // Test 4: out-of-range and misaligned fetches on CPU1
        reqValid = 3'b010; reqAddr[1] = 32'h400;
        @(negedge clk); reqValid = '0;
        @(negedge clk); #3;
        chk("T4 oor rspValid", 32'(rspValid), 32'h2);
        chk("T4 oor rspData1", rspData[1], 32'h00000013);
        chk("T4 oor addrErr", 32'(addrErr), 32'h2);
        @(negedge clk);
        reqValid = 3'b010; reqAddr[1] = 32'h32;
        @(negedge clk); reqValid = '0;
        @(negedge clk); #3;
        chk("T4 misaligned rspData1", rspData[1], 32'h00100513);
        chk("T4 misaligned addrErr", 32'(addrErr), 32'h2);

        // Test 5: reset while a read is in flight
        @(negedge clk);
        reqValid = 3'b010; reqAddr[1] = 32'h8;
        #3; chk("T5 grant", 32'(reqReady), 32'h2);
        @(negedge clk); rst_n = 1'b0; reqValid = '0;
        #3; chk("T5 memRdEn in reset", 32'(memRdEn), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        #3; chk("T5 no rsp t+2", 32'(rspValid), 32'h0);
        for (int k = 0; k < N; k++) chk("T5 rspData nop", rspData[k], 32'h00000013);
        @(negedge clk);
        reqValid = 3'b111; reqAddr = '0;
        #3; chk("T5 no rsp t+3", 32'(rspValid), 32'h0);
        chk("T5 pointer reset", 32'(reqReady), 32'h1);
        @(negedge clk); reqValid = '0;
        repeat (4) @(negedge clk);

        // Test 6: conflict counter wrap
        do_reset();
        @(negedge clk);
        reqValid = 3'b111; reqAddr = '0;
        #1;
        force dut.r_conflictCount = 32'hFFFFFFFE;
        preset_val = 32'hFFFFFFFE;
        preset_seq++;
        #2; chk("T6 preset", conflictCount, 32'hFFFFFFFE);
        #1; release dut.r_conflictCount;
        @(negedge clk); #3; chk("T6 first conflict", conflictCount, 32'hFFFFFFFF);
        @(negedge clk); #3; chk("T6 wrap", conflictCount, 32'h00000000);
        @(negedge clk); reqValid = '0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
